pb_scanner: RTL and testbench

Input-conditioning stage that sits directly upstream of the top-level lab logic on the 100 Hz board clock. It synchronizes and debounces the 21 raw pushbuttons, and provides clean held levels for direct use. It also turns each new press into a 5-bit key code, queued in a small FIFO and handed to the consumer with a valid/ready handshake.

---
 rtl/pb_scanner_if.sv | 15 +
 rtl/pb_scanner.sv | 126 ++++++++++++
 tb/tb_pb_scanner.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pb_scanner_if.sv
// Key-code handshake bundle between the pushbutton scanner (master) and its consumer (slave).
interface pb_scanner_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [4:0]    code;
  logic          valid;
  logic          ready;
  logic [CW-1:0] count;
  logic          overflow;

  modport master (output code, output valid, output count, output overflow, input ready);
  modport slave  (input code, input valid, input count, input overflow, output ready);
endinterface

// File: rtl/pb_scanner.sv
// Pushbutton conditioning: two-flop sync, per-bit debounce, press encoder and
// a small key-code FIFO with valid/ready pop and sticky overflow.
module pb_scanner #(
  parameter int unsigned NBTN   = 21,
  parameter int unsigned STABLE = 2,
  parameter int unsigned DEPTH  = 4
) (
  input  logic            hz100,
  input  logic            reset,
  input  logic [NBTN-1:0] pb,
  output logic [NBTN-1:0] held,
  pb_scanner_if.master    kq
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [NBTN-1:0]      s1_q, s2_q;
  logic [NBTN-1:0][3:0] cnt_q, cnt_d;
  logic [NBTN-1:0]      held_q, held_d;
  logic [NBTN-1:0]      held_dly_q;
  logic [4:0]           mem_q [DEPTH];
  logic [PW-1:0]        rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 valid_q, valid_d;
  logic [4:0]           code_q, code_d;

  logic [NBTN-1:0] rise;
  logic [4:0]      enc;
  logic            push_req, push, pop, full;
  logic [PW-1:0]   rd_nxt;

  // Debounce: accept a new level only after it persists STABLE cycles
  always_comb begin
    held_d = held_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < int'(NBTN); i++) begin
      if (s2_q[i] != held_q[i]) begin
        if (cnt_q[i] == 4'(STABLE - 1)) begin
          held_d[i] = s2_q[i];
          cnt_d[i]  = 4'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end else begin
        cnt_d[i] = 4'd0;
      end
    end
  end

  // Highest newly pressed index wins; later iterations override earlier ones
  always_comb begin
    rise = held_q & ~held_dly_q;
    enc  = 5'd0;
    for (int i = 0; i < int'(NBTN); i++) begin
      if (rise[i]) enc = 5'(i);
    end
  end

  always_comb begin
    push_req = |rise;
    full     = (count_q == CW'(DEPTH));
    pop      = valid_q & kq.ready;
    push     = push_req & (~full | pop);
    rd_nxt   = rd_q + PW'(1);
    rd_d     = pop  ? rd_nxt : rd_q;
    wr_d     = push ? wr_q + PW'(1) : wr_q;
    ovf_d    = ovf_q | (push_req & full & ~pop);
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    valid_d = (count_d != CW'(0));
    // Head register tracks mem[rd]; a lone entry being popped is replaced by the concurrent push
    code_d = code_q;
    if (pop) begin
      if (count_q == CW'(1)) begin
        if (push) code_d = enc;
      end else begin
        code_d = mem_q[rd_nxt];
      end
    end else if (push && count_q == CW'(0)) begin
      code_d = enc;
    end
  end

  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      cnt_q      <= '0;
      held_q     <= '0;
      held_dly_q <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      code_q     <= 5'd0;
    end else begin
      s1_q       <= pb;
      s2_q       <= s1_q;
      cnt_q      <= cnt_d;
      held_q     <= held_d;
      held_dly_q <= held_q;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
      code_q     <= code_d;
    end
  end

  always_ff @(posedge hz100) begin
    if (push) mem_q[wr_q] <= enc;
  end

  assign held        = held_q;
  assign kq.code     = code_q;
  assign kq.valid    = valid_q;
  assign kq.count    = count_q;
  assign kq.overflow = ovf_q;
endmodule

// File: tb/tb_pb_scanner.sv
// Directed bench for pb_scanner: reset, debounce latency, bounce rejection,
// encoder priority, FIFO fill/overflow and full push+pop.
module tb_pb_scanner;
  localparam int unsigned NBTN   = 21;
  localparam int unsigned STABLE = 2;
  localparam int unsigned DEPTH  = 4;

  logic            hz100;
  logic            reset;
  logic [NBTN-1:0] pb;
  logic [NBTN-1:0] held;

  int pass_cnt = 0;
  int total    = 0;

  pb_scanner_if #(.DEPTH(DEPTH)) kq ();

  pb_scanner #(.NBTN(NBTN), .STABLE(STABLE), .DEPTH(DEPTH)) dut (
    .hz100 (hz100),
    .reset (reset),
    .pb    (pb),
    .held  (held),
    .kq    (kq.master)
  );

  initial hz100 = 1'b0;
  always #5 hz100 = ~hz100;

  task automatic cyc(input int n);
    repeat (n) @(posedge hz100);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic press_release(input int b);
    pb[b] = 1'b1;
    cyc(5);
    pb[b] = 1'b0;
    cyc(5);
  endtask

  initial begin
    int exp_codes[4];
    reset    = 1'b1;
    pb       = '0;
    kq.ready = 1'b0;
    #2;
    reset = 1'b0;
    pb    = '1;
    cyc(3);
    chk("rst_held",  32'(held),        0);
    chk("rst_valid", 32'(kq.valid),    0);
    chk("rst_count", 32'(kq.count),    0);
    chk("rst_ovf",   32'(kq.overflow), 0);

    pb    = '0;
    reset = 1'b1;
    cyc(10);
    chk("idle_held",  32'(held),        0);
    chk("idle_valid", 32'(kq.valid),    0);
    chk("idle_count", 32'(kq.count),    0);
    chk("idle_ovf",   32'(kq.overflow), 0);

    // Single press on button 5
    pb[5] = 1'b1;
    cyc(3);
    chk("p5_held_e3", 32'(held[5]), 0);
    cyc(1);
    chk("p5_held_e4",  32'(held[5]),  1);
    chk("p5_valid_e4", 32'(kq.valid), 0);
    cyc(1);
    chk("p5_valid_e5", 32'(kq.valid), 1);
    chk("p5_code",     32'(kq.code),  5);
    chk("p5_count",    32'(kq.count), 1);
    kq.ready = 1'b1;
    cyc(1);
    kq.ready = 1'b0;
    chk("p5_pop_valid", 32'(kq.valid), 0);
    chk("p5_pop_count", 32'(kq.count), 0);
    pb[5] = 1'b0;
    cyc(6);
    chk("p5_rel_held",  32'(held),     0);
    chk("p5_rel_valid", 32'(kq.valid), 0);

    // Bounce on button 3 is rejected, then a steady press is accepted
    for (int k = 0; k < 4; k++) begin
      pb[3] = (k % 2 == 0);
      cyc(1);
      chk("bnc_held_step", 32'(held[3]), 0);
    end
    pb[3] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      chk("bnc_held_settle", 32'(held[3]), 0);
    end
    chk("bnc_valid", 32'(kq.valid), 0);
    pb[3] = 1'b1;
    cyc(4);
    chk("b3_valid_e4", 32'(kq.valid), 0);
    cyc(1);
    chk("b3_valid", 32'(kq.valid), 1);
    chk("b3_code",  32'(kq.code),  3);
    kq.ready = 1'b1;
    cyc(1);
    kq.ready = 1'b0;
    pb[3] = 1'b0;
    cyc(6);
    chk("b3_drain", 32'(kq.count), 0);

    // Simultaneous rises: highest index is the only entry
    pb[2]  = 1'b1;
    pb[17] = 1'b1;
    cyc(5);
    chk("sim_count", 32'(kq.count), 1);
    chk("sim_code",  32'(kq.code),  17);
    chk("sim_h2",    32'(held[2]),  1);
    chk("sim_h17",   32'(held[17]), 1);
    cyc(3);
    chk("sim_count_later", 32'(kq.count), 1);
    kq.ready = 1'b1;
    cyc(1);
    kq.ready = 1'b0;
    pb = '0;
    cyc(6);
    chk("sim_drain", 32'(kq.count), 0);

    // Fill to DEPTH, fifth press dropped
    press_release(1);
    chk("fill1_count", 32'(kq.count), 1);
    chk("fill1_code",  32'(kq.code),  1);
    press_release(2);
    press_release(3);
    chk("fill3_count", 32'(kq.count), 3);
    press_release(4);
    chk("fill4_count", 32'(kq.count),    4);
    chk("fill4_ovf",   32'(kq.overflow), 0);
    press_release(6);
    chk("fill5_count", 32'(kq.count),    4);
    chk("fill5_ovf",   32'(kq.overflow), 1);
    exp_codes = '{1, 2, 3, 4};
    for (int k = 0; k < 4; k++) begin
      chk("ovf_pop_code", 32'(kq.code), 32'(exp_codes[k]));
      kq.ready = 1'b1;
      cyc(1);
    end
    kq.ready = 1'b0;
    chk("ovf_empty_valid", 32'(kq.valid),    0);
    chk("ovf_empty_count", 32'(kq.count),    0);
    chk("ovf_sticky",      32'(kq.overflow), 1);
    kq.ready = 1'b1;
    cyc(2);
    kq.ready = 1'b0;
    chk("underflow_count", 32'(kq.count), 0);

    // Reset clears the sticky flag immediately
    reset = 1'b0;
    #1;
    chk("midrst_ovf",   32'(kq.overflow), 0);
    chk("midrst_count", 32'(kq.count),    0);
    cyc(1);
    reset = 1'b1;
    cyc(1);

    // Full FIFO: pop and push of code 9 on the same edge
    press_release(1);
    press_release(2);
    press_release(3);
    press_release(4);
    chk("full_count", 32'(kq.count), 4);
    pb[9] = 1'b1;
    cyc(4);
    kq.ready = 1'b1;
    cyc(1);
    kq.ready = 1'b0;
    chk("pp_count", 32'(kq.count),    4);
    chk("pp_ovf",   32'(kq.overflow), 0);
    chk("pp_head",  32'(kq.code),     2);
    pb[9] = 1'b0;
    exp_codes = '{2, 3, 4, 9};
    for (int k = 0; k < 4; k++) begin
      chk("pp_pop_code", 32'(kq.code), 32'(exp_codes[k]));
      kq.ready = 1'b1;
      cyc(1);
    end
    kq.ready = 1'b0;
    chk("pp_empty", 32'(kq.valid), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
